// File: rtl/ext_bus_responder_pkg.sv
// Shared encodings for the external bus responder:
// FSM states, rw bit position on the data pins, CPU phase levels.
package ext_bus_responder_pkg;

   typedef enum logic [1:0] {
      S_LO     = 2'd0,
      S_HI_DEC = 2'd1,
      S_HI_RD  = 2'd2,
      S_HI_WR  = 2'd3
   } state_t;

   localparam int   RW_BIT = 0;
   localparam logic PH_LO  = 1'b0;
   localparam logic PH_HI  = 1'b1;

endpackage

// File: rtl/ext_bus_responder_resp_ram.sv
// Single-port byte RAM for the responder window:
// synchronous write, registered read, contents not reset.
module ext_bus_responder_resp_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/ext_bus_responder.sv
// Memory-side end of the CPU multiplexed external bus: address demux,
// window decode, read drive / write capture, host preload port.
module ext_bus_responder
   import ext_bus_responder_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          AW        = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_phase,
   input  logic [7:0]    addr_mux,
   input  logic [7:0]    bus_in,
   output logic [7:0]    bus_out,
   output logic          bus_oe,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [AW-1:0] load_addr,
   input  logic [7:0]    load_data,
   output logic [15:0]   last_addr,
   output logic          hit
);

   localparam logic [15:0] WIN_MASK = ~16'(DEPTH - 1);

   state_t        state_q, state_n;
   logic          ph_q, rise, fall;
   logic [7:0]    lo_q, hi_q, wd_q, rdata;
   logic          rw_q, hit_q, oe_q;
   logic [15:0]   addr_q, addr_n;
   logic          hit_n, rd_en, cpu_wr, load_fire;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;

   assign rise = (cpu_phase == PH_HI) && (ph_q == PH_LO);
   assign fall = (cpu_phase == PH_LO) && (ph_q == PH_HI);

   // A too-short high phase falls in S_HI_DEC; hi_q keeps the high byte then.
   assign addr_n = {(cpu_phase == PH_HI) ? addr_mux : hi_q, lo_q};
   assign hit_n  = (addr_n & WIN_MASK) == BASE_ADDR;

   always_comb begin
      state_n = state_q;
      rd_en   = 1'b0;
      cpu_wr  = 1'b0;
      unique case (state_q)
         S_LO: begin
            if (rise) state_n = S_HI_DEC;
         end
         S_HI_DEC: begin
            if (fall) begin
               state_n = S_LO;
            end else if (rw_q && hit_n) begin
               state_n = S_HI_RD;
               rd_en   = 1'b1;
            end else begin
               state_n = S_HI_WR;
            end
         end
         S_HI_RD: begin
            if (fall) state_n = S_LO;
         end
         S_HI_WR: begin
            if (fall) begin
               state_n = S_LO;
               cpu_wr  = ~rw_q & hit_q;
            end
         end
         default: state_n = S_LO;
      endcase
   end

   assign load_fire  = load_valid & rw_q & (state_q == S_LO);
   assign load_ready = load_fire;

   assign ram_we    = cpu_wr | load_fire;
   assign ram_wdata = cpu_wr ? wd_q : load_data;
   assign ram_addr  = cpu_wr ? addr_q[AW-1:0] :
                      rd_en  ? addr_n[AW-1:0] : load_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_LO;
         ph_q      <= PH_LO;
         lo_q      <= '0;
         hi_q      <= '0;
         rw_q      <= 1'b0;
         wd_q      <= '0;
         addr_q    <= '0;
         hit_q     <= 1'b0;
         oe_q      <= 1'b0;
         last_addr <= '0;
         hit       <= 1'b0;
      end else begin
         state_q <= state_n;
         ph_q    <= cpu_phase;
         if (state_q == S_LO && cpu_phase == PH_LO) begin
            lo_q <= addr_mux;
            rw_q <= bus_in[RW_BIT];
         end
         if (state_q == S_LO && rise) hi_q <= addr_mux;
         if (state_q != S_LO && cpu_phase == PH_HI) wd_q <= bus_in;
         if (state_q == S_HI_DEC && !fall) begin
            addr_q <= addr_n;
            hit_q  <= hit_n;
         end
         if (fall && state_q == S_HI_DEC) begin
            last_addr <= addr_n;
            hit       <= hit_n;
         end else if (fall && state_q != S_LO) begin
            last_addr <= addr_q;
            hit       <= hit_q;
         end
         if (fall) oe_q <= 1'b0;
         else if (rd_en) oe_q <= 1'b1;
      end
   end

   assign bus_oe  = oe_q;
   assign bus_out = oe_q ? rdata : 8'h00;

   ext_bus_responder_resp_ram #(
      .AW(AW)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .re   (rd_en),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(rdata)
   );

endmodule
